// File: rtl/audio_pkg.sv
// Shared constants and helpers for the footstep audio output path.
package audio_pkg;

    // Divider value meaning "no tone"; any tone at or above it is silent.
    localparam logic [31:0] SIL_DIV = 32'd50000000;

    // Amplitude added per volume step.
    localparam logic [15:0] AMP_STEP = 16'h0800;

    // Frame counter width: 512 clk per stereo frame.
    localparam int FRAME_BITS = 9;

    // Slot index width: 16 slots per half-frame.
    localparam int SLOT_BITS = 4;

    // Sample word width.
    localparam int SAMPLE_W = 16;

    // Peak amplitude for a volume setting; 7 * 0x0800 still fits in 16 bits.
    function automatic logic [SAMPLE_W-1:0] amp_of(input logic [2:0] vol);
        return SAMPLE_W'(vol) * AMP_STEP;
    endfunction

endpackage

// File: rtl/square_tone_gen.sv
// One channel of square-wave tone generation: a half-period divider plus a phase
// bit. The phase and volume are turned into a signed 16-bit sample.
module square_tone_gen
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         tone,
    input  logic [2:0]          volume,
    output logic [SAMPLE_W-1:0] sample
);

    logic [31:0]         cnt_q, cnt_d;
    logic                ph_q, ph_d;
    logic [31:0]         tone_q, tone_d;
    logic                silent;
    logic [SAMPLE_W-1:0] amp;

    // Divider/phase next state; a tone change restarts the count without touching phase.
    always_comb begin
        silent = (tone == 32'd0) || (tone >= SIL_DIV);
        cnt_d  = cnt_q + 32'd1;
        ph_d   = ph_q;
        tone_d = tone;
        if (silent) begin
            cnt_d = 32'd0;
            ph_d  = 1'b0;
        end else if (tone != tone_q) begin
            cnt_d = 32'd0;
        end else if (cnt_q == tone) begin
            cnt_d = 32'd0;
            ph_d  = ~ph_q;
        end
    end

    // Divider, phase and registered tone copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 32'd0;
            ph_q   <= 1'b0;
            tone_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            ph_q   <= ph_d;
            tone_q <= tone_d;
        end
    end

    // Sample is +amp on the high phase and -amp on the low phase; silence forces zero.
    always_comb begin
        amp = amp_of(volume);
        if (silent) begin
            sample = '0;
        end else if (ph_q) begin
            sample = amp;
        end else begin
            sample = SAMPLE_W'(0) - amp;
        end
    end

endmodule

// File: rtl/footstep_audio_out.sv
// Footstep audio output: two square-wave tone channels serialised onto a 16-bit
// stereo I2S link. All link clocks are bits of one free-running frame counter.
module footstep_audio_out
    import audio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] toneL,
    input  logic [31:0] toneR,
    input  logic [2:0]  volume,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    localparam logic [FRAME_BITS-1:0] FRAME_LAST = '1;

    logic [FRAME_BITS-1:0] fc_q, fc_d;
    logic [SAMPLE_W-1:0]   sample_l, sample_r;
    logic [SAMPLE_W-1:0]   word_l_q, word_l_d;
    logic [SAMPLE_W-1:0]   word_r_q, word_r_d;
    logic                  r_lsb_q, r_lsb_d;
    logic                  sdin_q, sdin_d;
    logic [SLOT_BITS-1:0]  slot;
    logic [SLOT_BITS-1:0]  bit_idx;

    square_tone_gen u_tone_l (
        .clk    (clk),
        .rst_n  (rst_n),
        .tone   (toneL),
        .volume (volume),
        .sample (sample_l)
    );

    square_tone_gen u_tone_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .tone   (toneR),
        .volume (volume),
        .sample (sample_r)
    );

    // Frame counter simply wraps; the 511 -> 0 edge is also the word-latch edge.
    always_comb begin
        fc_d = fc_q + FRAME_BITS'(1);
    end

    // Latch both samples once per frame and keep the outgoing right LSB for the next left slot 0.
    always_comb begin
        word_l_d = word_l_q;
        word_r_d = word_r_q;
        r_lsb_d  = r_lsb_q;
        if (fc_q == FRAME_LAST) begin
            word_l_d = sample_l;
            word_r_d = sample_r;
            r_lsb_d  = word_r_q[0];
        end
    end

    // Serial bit for the slot fc is about to enter; 16 - slot selects bits 15..1 for slots 1..15.
    // At the wrap edge r_lsb_q is being updated, so left slot 0 reads the live right LSB instead.
    always_comb begin
        slot    = fc_d[FRAME_BITS-2 -: SLOT_BITS];
        bit_idx = SLOT_BITS'(0) - slot;
        sdin_d  = 1'b0;
        if (!fc_d[FRAME_BITS-1]) begin
            if (slot == '0) begin
                sdin_d = (fc_q == FRAME_LAST) ? word_r_q[0] : r_lsb_q;
            end else begin
                sdin_d = word_l_q[bit_idx];
            end
        end else begin
            if (slot == '0) begin
                sdin_d = word_l_q[0];
            end else begin
                sdin_d = word_r_q[bit_idx];
            end
        end
    end

    // Frame counter, latched words and serial data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_q     <= '0;
            word_l_q <= '0;
            word_r_q <= '0;
            r_lsb_q  <= 1'b0;
            sdin_q   <= 1'b0;
        end else begin
            fc_q     <= fc_d;
            word_l_q <= word_l_d;
            word_r_q <= word_r_d;
            r_lsb_q  <= r_lsb_d;
            sdin_q   <= sdin_d;
        end
    end

    assign audio_mclk = fc_q[1];
    assign audio_sck  = fc_q[3];
    assign audio_lrck = fc_q[FRAME_BITS-1];
    assign audio_sdin = sdin_q;

endmodule

// File: tb/tb_footstep_audio_out.sv
// Self-checking bench for footstep_audio_out: decodes the I2S stream and compares
// against a reference model of the square-wave tones.
module tb_footstep_audio_out;
    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] toneL = 32'd50000000;
    logic [31:0] toneR = 32'd50000000;
    logic [2:0]  volume = 3'd0;
    logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;

    int n_checks = 0;
    int n_fail = 0;

    // Number of rising edges since reset release, i.e. the expected frame position.
    int cyc;

    // Reference model state: tone/volume in effect and the edge index of the last restart.
    logic [31:0] m_tone_l, m_tone_r;
    logic [2:0]  m_vol;
    int          e0_l, e0_r;

    // Captured serial bits per frame (index = slot 0..31) and decoded/expected words.
    logic [31:0] stream [10];
    logic [15:0] exp_l [10];
    logic [15:0] exp_r [10];
    logic [15:0] dec_l [10];
    logic [15:0] dec_r [10];

    footstep_audio_out dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .toneL      (toneL),
        .toneR      (toneR),
        .volume     (volume),
        .audio_mclk (audio_mclk),
        .audio_lrck (audio_lrck),
        .audio_sck  (audio_sck),
        .audio_sdin (audio_sdin)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Edge counter restarted by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Expected sample: phase starts low at the restart edge and flips every tone+1 clk.
    function automatic logic [15:0] model_sample(input logic [31:0] tone, input logic [2:0] vol,
                                                 input int e0, input int now);
        longint j, half;
        int amp;
        if (tone == 32'd0 || tone >= 32'd50000000) return 16'h0000;
        amp  = int'(vol) * 2048;
        j    = longint'(now - e0);
        half = longint'(tone) + 1;
        if (((j / half) % 2) == 1) return 16'(amp);
        return 16'(-amp);
    endfunction

    // Pass through silence so both phases are low, then apply tones; restart edge is the next one.
    task automatic set_tones(input logic [31:0] tl, input logic [31:0] tr, input logic [2:0] v);
        @(negedge clk);
        toneL = 32'd50000000;
        toneR = 32'd50000000;
        volume = v;
        repeat (2) @(negedge clk);
        toneL = tl;
        toneR = tr;
        m_tone_l = tl;
        m_tone_r = tr;
        m_vol = v;
        e0_l = cyc;
        e0_r = cyc;
    endtask

    // Capture nframes frames from a frame boundary and decode nframes-2 complete word pairs.
    task automatic run_and_decode(input int nframes);
        int guard;
        int fc;
        guard = 0;
        while ((cyc % 512) != 0 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        for (int f = 0; f < nframes; f++) begin
            stream[f] = '0;
            for (int k = 0; k < 512; k++) begin
                fc = cyc % 512;
                if ((fc % 16) == 8) stream[f][fc / 16] = audio_sdin;
                if (fc == 511) begin
                    exp_l[f] = model_sample(m_tone_l, m_vol, e0_l, cyc - 1);
                    exp_r[f] = model_sample(m_tone_r, m_vol, e0_r, cyc - 1);
                end
                @(negedge clk);
            end
        end
        for (int f = 0; f + 2 < nframes; f++) begin
            for (int b = 0; b < 15; b++) begin
                dec_l[f][15-b] = stream[f+1][1+b];
                dec_r[f][15-b] = stream[f+1][17+b];
            end
            dec_l[f][0] = stream[f+1][16];
            dec_r[f][0] = stream[f+2][0];
        end
    endtask

    task automatic test_reset();
        logic [2:0] exp_clk;
        rst_n = 1'b0;
        repeat (20) begin
            @(negedge clk);
            n_checks++;
            if ({audio_mclk, audio_lrck, audio_sck, audio_sdin} !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs: got %b expected 0000",
                         {audio_mclk, audio_lrck, audio_sck, audio_sdin});
            end
        end
        rst_n = 1'b1;
        m_tone_l = 32'd50000000;
        m_tone_r = 32'd50000000;
        m_vol = 3'd0;
        repeat (1100) begin
            @(negedge clk);
            exp_clk = {cyc[1], cyc[3], cyc[8]};
            n_checks++;
            if ({audio_mclk, audio_sck, audio_lrck} !== exp_clk) begin
                n_fail++;
                $display("[TB] FAIL link_clocks cyc=%0d: got mclk/sck/lrck=%b expected %b",
                         cyc, {audio_mclk, audio_sck, audio_lrck}, exp_clk);
            end
        end
    endtask

    task automatic test_silence();
        set_tones(32'd50000000, 32'd50000000, 3'd7);
        repeat (1024) @(negedge clk);
        repeat (2048) begin
            @(negedge clk);
            n_checks++;
            if (audio_sdin !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL silence_sdin cyc=%0d: got %b expected 0", cyc, audio_sdin);
            end
        end
    endtask

    task automatic test_tone_right();
        logic [15:0] e;
        set_tones(32'd50000000, 32'd10, 3'd4);
        repeat (120) begin
            @(negedge clk);
            e = model_sample(32'd10, 3'd4, e0_r, cyc - 1);
            n_checks++;
            if (dut.u_tone_r.sample !== e) begin
                n_fail++;
                $display("[TB] FAIL sample_r cyc=%0d: got %h expected %h", cyc, dut.u_tone_r.sample, e);
            end
            n_checks++;
            if (dut.u_tone_l.sample !== 16'h0000) begin
                n_fail++;
                $display("[TB] FAIL sample_l_silent: got %h expected 0000", dut.u_tone_l.sample);
            end
        end
        run_and_decode(4);
        for (int f = 0; f < 2; f++) begin
            n_checks++;
            if (dec_r[f] !== exp_r[f] || (dec_r[f] !== 16'h2000 && dec_r[f] !== 16'hE000)) begin
                n_fail++;
                $display("[TB] FAIL tone_right_word %0d: got %h expected %h", f, dec_r[f], exp_r[f]);
            end
            n_checks++;
            if (dec_l[f] !== 16'h0000) begin
                n_fail++;
                $display("[TB] FAIL tone_right_left_word %0d: got %h expected 0000", f, dec_l[f]);
            end
        end
    endtask

    // Huge divider: phase stays low after the restart, so both words are -0x0800.
    task automatic test_const_phase();
        set_tones(32'd49999999, 32'd49999999, 3'd1);
        run_and_decode(4);
        for (int f = 0; f < 2; f++) begin
            n_checks++;
            if (dec_l[f] !== exp_l[f]) begin
                n_fail++;
                $display("[TB] FAIL const_left_word %0d: got %h expected %h", f, dec_l[f], exp_l[f]);
            end
            n_checks++;
            if (dec_r[f] !== exp_r[f]) begin
                n_fail++;
                $display("[TB] FAIL const_right_word %0d: got %h expected %h", f, dec_r[f], exp_r[f]);
            end
        end
    endtask

    task automatic test_tone_change();
        int guard;
        int n;
        logic ph_save;
        set_tones(32'd10, 32'd50000000, 3'd1);
        guard = 0;
        while (dut.u_tone_l.cnt_q !== 32'd5 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 50) begin
            n_fail++;
            $display("[TB] FAIL wait_cnt5: got cnt %0d expected 5", dut.u_tone_l.cnt_q);
        end
        ph_save = dut.u_tone_l.ph_q;
        toneL = 32'd20;
        @(negedge clk);
        n_checks++;
        if (dut.u_tone_l.cnt_q !== 32'd0 || dut.u_tone_l.ph_q !== ph_save) begin
            n_fail++;
            $display("[TB] FAIL tone_change_restart: got cnt %0d ph %b expected cnt 0 ph %b",
                     dut.u_tone_l.cnt_q, dut.u_tone_l.ph_q, ph_save);
        end
        n = 0;
        while (dut.u_tone_l.ph_q === ph_save && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != 21) begin
            n_fail++;
            $display("[TB] FAIL tone_change_period: got %0d clk expected 21", n);
        end
        // Change arriving on the same cycle as cnt == tone: restart wins, no toggle.
        guard = 0;
        while (dut.u_tone_l.cnt_q !== 32'd20 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ph_save = dut.u_tone_l.ph_q;
        toneL = 32'd15;
        @(negedge clk);
        n_checks++;
        if (guard >= 50 || dut.u_tone_l.cnt_q !== 32'd0 || dut.u_tone_l.ph_q !== ph_save) begin
            n_fail++;
            $display("[TB] FAIL change_at_terminal: got cnt %0d ph %b expected cnt 0 ph %b",
                     dut.u_tone_l.cnt_q, dut.u_tone_l.ph_q, ph_save);
        end
    endtask

    task automatic test_random();
        logic [31:0] t [2];
        int r;
        logic [2:0] v;
        for (int it = 0; it < 5; it++) begin
            for (int c = 0; c < 2; c++) begin
                r = $urandom_range(0, 7);
                if (r == 0)      t[c] = 32'd50000000 + $urandom_range(0, 1000);
                else if (r == 1) t[c] = 32'd0;
                else             t[c] = $urandom_range(1, 600);
            end
            v = 3'($urandom_range(0, 7));
            set_tones(t[0], t[1], v);
            run_and_decode(4);
            for (int f = 0; f < 2; f++) begin
                n_checks++;
                if (dec_l[f] !== exp_l[f]) begin
                    n_fail++;
                    $display("[TB] FAIL random_left it=%0d f=%0d tone=%0d vol=%0d: got %h expected %h",
                             it, f, t[0], v, dec_l[f], exp_l[f]);
                end
                n_checks++;
                if (dec_r[f] !== exp_r[f]) begin
                    n_fail++;
                    $display("[TB] FAIL random_right it=%0d f=%0d tone=%0d vol=%0d: got %h expected %h",
                             it, f, t[1], v, dec_r[f], exp_r[f]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int guard;
        set_tones(32'd7, 32'd13, 3'd5);
        repeat (700) @(negedge clk);
        guard = 0;
        while ((cyc % 512) != 300 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        // fc = 300 has lrck and sck high, so the async clear is visible.
        n_checks++;
        if (audio_lrck !== 1'b1 || audio_sck !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_clocks: got lrck %b sck %b expected 1 1", audio_lrck, audio_sck);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({audio_mclk, audio_lrck, audio_sck, audio_sdin} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %b expected 0000",
                     {audio_mclk, audio_lrck, audio_sck, audio_sdin});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e0_l = 0;
        e0_r = 0;
        run_and_decode(3);
        n_checks++;
        if (stream[0] !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL first_frame_zero: got %h expected 00000000", stream[0]);
        end
        n_checks++;
        if (dec_l[0] !== exp_l[0] || dec_r[0] !== exp_r[0]) begin
            n_fail++;
            $display("[TB] FAIL post_reset_words: got %h/%h expected %h/%h",
                     dec_l[0], dec_r[0], exp_l[0], exp_r[0]);
        end
    endtask

    initial begin
        test_reset();
        test_silence();
        test_tone_right();
        test_const_phase();
        test_tone_change();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
